// File: rtl/mw_wb_stage_pkg.sv
// Purpose: shared opcode/func constants, write-back control encodings and the W-stage decoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mw_wb_stage_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  // R-type function codes (Instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {M2R_ALU = 2'b00, M2R_MEM = 2'b01, M2R_PC8 = 2'b10} mem2reg_e;
  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_31 = 2'b10} regdst_e;
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ldop_e;

  typedef struct packed {
    logic     wr;    // member of the write set
    logic     cond;  // write further gated by CondOK (movz)
    mem2reg_e m2r;
    regdst_e  dst;
    ldop_e    ld;
  } wb_ctrl_t;

  function automatic wb_ctrl_t wb_decode(input logic [5:0] op, input logic [5:0] fn);
    wb_ctrl_t c;
    c = '{wr: 1'b0, cond: 1'b0, m2r: M2R_ALU, dst: DST_RT, ld: LD_W};
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin c.wr = 1'b1; c.dst = DST_RD; end
          FN_JALR: begin c.wr = 1'b1; c.dst = DST_RD; c.m2r = M2R_PC8; end
          FN_MOVZ: begin c.wr = 1'b1; c.cond = 1'b1; c.dst = DST_RD; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c.wr = 1'b1;
      OP_LW:  begin c.wr = 1'b1; c.m2r = M2R_MEM; c.ld = LD_W;  end
      OP_LB:  begin c.wr = 1'b1; c.m2r = M2R_MEM; c.ld = LD_B;  end
      OP_LBU: begin c.wr = 1'b1; c.m2r = M2R_MEM; c.ld = LD_BU; end
      OP_LH:  begin c.wr = 1'b1; c.m2r = M2R_MEM; c.ld = LD_H;  end
      OP_LHU: begin c.wr = 1'b1; c.m2r = M2R_MEM; c.ld = LD_HU; end
      OP_JAL: begin c.wr = 1'b1; c.dst = DST_31; c.m2r = M2R_PC8; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mw_wb_stage_load_ext.sv
// Purpose: select byte/half of a little-endian memory word and sign/zero extend it.
// Latency: combinational.
// Backpressure: none.
// Ports: word = raw aligned word, a = byte offset, op = load kind, ext = extended result.
module load_ext
  import mw_wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  ldop_e       op,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (a)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // a[0] is deliberately ignored for halves; misalignment is not trapped here.
  assign half_sel = a[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext = word;
    case (op)
      LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ext = {24'd0, byte_sel};
      LD_H:    ext = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ext = {16'd0, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mw_wb_stage.sv
// Purpose: M->W pipeline register plus register-file write-back select.
// Latency: 1 cycle from M inputs to W outputs.
// Backpressure: en=0 stalls (all state holds); clr inserts a bubble; reset beats clr beats en.
// Ports: clk/reset; en/clr control; *_M inputs from M stage; RegWrite_W/A3_W/WD_W to the
// register file; Instr_W/PC_W copies for hazard logic and debug.
module mw_wb_stage
  import mw_wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] Instr_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] DMRead_M,
  input  logic        CondOK_M,
  output logic        RegWrite_W,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic [31:0] Instr_W,
  output logic [31:0] PC_W
);

  logic [31:0] instr_q, pc_q, alu_q, dm_q;
  logic [31:0] instr_d, pc_d, alu_d, dm_d;
  logic        cond_q, cond_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    dm_d    = dm_q;
    cond_d  = cond_q;
    if (clr) begin
      // An all-zero word decodes as sll $0 and therefore never writes.
      instr_d = '0;
      pc_d    = '0;
      alu_d   = '0;
      dm_d    = '0;
      cond_d  = 1'b0;
    end else if (en) begin
      instr_d = Instr_M;
      pc_d    = PC_M;
      alu_d   = ALUOut_M;
      dm_d    = DMRead_M;
      cond_d  = CondOK_M;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      dm_q    <= '0;
      cond_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
      cond_q  <= cond_d;
    end
  end

  wb_ctrl_t    ctrl;
  logic [31:0] ld_data;

  assign ctrl = wb_decode(instr_q[31:26], instr_q[5:0]);

  load_ext u_load_ext (
    .word (dm_q),
    .a    (alu_q[1:0]),
    .op   (ctrl.ld),
    .ext  (ld_data)
  );

  always_comb begin
    case (ctrl.dst)
      DST_RD:  A3_W = instr_q[15:11];
      DST_31:  A3_W = 5'd31;
      default: A3_W = instr_q[20:16];
    endcase
  end

  always_comb begin
    case (ctrl.m2r)
      M2R_MEM: WD_W = ld_data;
      M2R_PC8: WD_W = pc_q + 32'd8;
      default: WD_W = alu_q;
    endcase
  end

  // Writes to $0 are suppressed so the register file never needs its own guard.
  assign RegWrite_W = ctrl.wr && (!ctrl.cond || cond_q) && (A3_W != 5'd0);
  assign Instr_W    = instr_q;
  assign PC_W       = pc_q;

endmodule

// File: tb/tb_mw_wb_stage.sv
module tb_mw_wb_stage;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] Instr_M, PC_M, ALUOut_M, DMRead_M;
  logic        CondOK_M;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W, Instr_W, PC_W;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  mw_wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .Instr_M    (Instr_M),
    .PC_M       (PC_M),
    .ALUOut_M   (ALUOut_M),
    .DMRead_M   (DMRead_M),
    .CondOK_M   (CondOK_M),
    .RegWrite_W (RegWrite_W),
    .A3_W       (A3_W),
    .WD_W       (WD_W),
    .Instr_W    (Instr_W),
    .PC_W       (PC_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: W-stage contents follow reset > clr > en; outputs come
  // straight from the instruction-set meaning of the held instruction.
  logic [31:0] m_instr, m_pc, m_alu, m_dm;
  logic        m_cond;

  always @(posedge clk) begin
    if (reset || clr) begin
      m_instr <= 0; m_pc <= 0; m_alu <= 0; m_dm <= 0; m_cond <= 0;
    end else if (en) begin
      m_instr <= Instr_M; m_pc <= PC_M; m_alu <= ALUOut_M; m_dm <= DMRead_M; m_cond <= CondOK_M;
    end
  end

  function automatic void model_out(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] alu, input logic [31:0] dm,
                                    input logic cond, output logic rw,
                                    output logic [4:0] a3, output logic [31:0] wd);
    logic [5:0]  op, fn;
    logic [7:0]  b;
    logic [15:0] h;
    logic        w;
    op = ins[31:26];
    fn = ins[5:0];
    b  = 8'(dm >> (8 * alu[1:0]));
    h  = alu[1] ? dm[31:16] : dm[15:0];
    w  = 1'b0;
    a3 = ins[20:16];
    wd = alu;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        w = 1'b1; a3 = ins[15:11];
      end else if (fn == 6'h09) begin
        w = 1'b1; a3 = ins[15:11]; wd = pc + 32'd8;
      end else if (fn == 6'h0A) begin
        w = cond; a3 = ins[15:11];
      end
    end else if (op inside {[6'h08:6'h0F]}) begin
      w = 1'b1;
    end else if (op == 6'h23) begin w = 1'b1; wd = dm;
    end else if (op == 6'h20) begin w = 1'b1; wd = {{24{b[7]}}, b};
    end else if (op == 6'h24) begin w = 1'b1; wd = {24'd0, b};
    end else if (op == 6'h21) begin w = 1'b1; wd = {{16{h[15]}}, h};
    end else if (op == 6'h25) begin w = 1'b1; wd = {16'd0, h};
    end else if (op == 6'h03) begin w = 1'b1; a3 = 5'd31; wd = pc + 32'd8;
    end
    rw = w && (a3 != 5'd0);
  endfunction

  // Compare process: every falling edge once the first reset edge has passed.
  always @(negedge clk) begin
    logic        e_rw;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    if (started) begin
      model_out(m_instr, m_pc, m_alu, m_dm, m_cond, e_rw, e_a3, e_wd);
      chk("m_regwrite", 32'(RegWrite_W), 32'(e_rw));
      chk("m_a3",       32'(A3_W),       32'(e_a3));
      chk("m_wd",       WD_W,            e_wd);
      chk("m_instr",    Instr_W,         m_instr);
      chk("m_pc",       PC_W,            m_pc);
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic cond);
    Instr_M = ins; PC_M = pc; ALUOut_M = alu; DMRead_M = dm; CondOK_M = cond;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clr = 1'b1;
    drive(32'h8C08_0010, 32'h0000_1234, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    cyc();
    started = 1'b1;
    chk("rst_instr", Instr_W, 32'h0);
    chk("rst_pc",    PC_W,    32'h0);
    chk("rst_rw",    32'(RegWrite_W), 32'h0);
    chk("rst_a3",    32'(A3_W), 32'h0);
    chk("rst_wd",    WD_W,    32'h0);

    reset = 1'b0; clr = 1'b0; en = 1'b1;
    // Load extension against DMRead = 80FF_1234
    drive({6'h20, 5'd1, 5'd9, 16'h0002}, 32'h400, 32'h0000_1002, 32'h80FF_1234, 1'b0); cyc();
    chk("lb_a2_wd", WD_W, 32'hFFFF_FFFF);
    chk("lb_a3",    32'(A3_W), 32'd9);
    chk("lb_rw",    32'(RegWrite_W), 32'd1);
    drive({6'h24, 5'd1, 5'd10, 16'h0002}, 32'h404, 32'h0000_1002, 32'h80FF_1234, 1'b0); cyc();
    chk("lbu_a2_wd", WD_W, 32'h0000_00FF);
    drive({6'h21, 5'd1, 5'd11, 16'h0002}, 32'h408, 32'h0000_1002, 32'h80FF_1234, 1'b0); cyc();
    chk("lh_a2_wd", WD_W, 32'hFFFF_80FF);
    drive({6'h25, 5'd1, 5'd11, 16'h0003}, 32'h40C, 32'h0000_1003, 32'h80FF_1234, 1'b0); cyc();
    chk("lhu_a3_wd", WD_W, 32'h0000_80FF);
    drive({6'h23, 5'd1, 5'd12, 16'h0001}, 32'h410, 32'h0000_1001, 32'h80FF_1234, 1'b0); cyc();
    chk("lw_a1_wd", WD_W, 32'h80FF_1234);
    drive({6'h20, 5'd1, 5'd13, 16'h0003}, 32'h414, 32'h0000_1003, 32'h80FF_1234, 1'b0); cyc();
    chk("lb_a3_wd", WD_W, 32'hFFFF_FF80);
    drive({6'h20, 5'd1, 5'd13, 16'h0000}, 32'h418, 32'h0000_1000, 32'h80FF_1234, 1'b0); cyc();
    chk("lb_a0_wd", WD_W, 32'h0000_0034);

    // jal / jalr
    drive({6'h03, 26'h0000C00}, 32'h0000_3000, 32'h55, 32'h0, 1'b0); cyc();
    chk("jal_a3", 32'(A3_W), 32'd31);
    chk("jal_wd", WD_W, 32'h0000_3008);
    chk("jal_rw", 32'(RegWrite_W), 32'd1);
    drive(32'h0080_0009, 32'h0000_3100, 32'h66, 32'h0, 1'b0); cyc();
    chk("jalr_rd0_rw", 32'(RegWrite_W), 32'd0);

    // movz rd=5
    drive(32'h0043_280A, 32'h0000_3200, 32'h77, 32'h0, 1'b0); cyc();
    chk("movz_c0_rw", 32'(RegWrite_W), 32'd0);
    drive(32'h0043_280A, 32'h0000_3204, 32'h77, 32'h0, 1'b1); cyc();
    chk("movz_c1_rw", 32'(RegWrite_W), 32'd1);
    chk("movz_c1_a3", 32'(A3_W), 32'd5);

    // addu then three stalled cycles with changing M inputs
    drive(32'h0022_3821, 32'h0000_0500, 32'h1234_5678, 32'h0, 1'b0); cyc();
    chk("addu_wd", WD_W, 32'h1234_5678);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive({6'h24, 5'd1, 5'(i + 2), 16'h0001}, 32'h900 + 32'(i), 32'hA0 + 32'(i), 32'hCAFE_F00D, 1'b1);
      cyc();
      chk("stall_wd",    WD_W, 32'h1234_5678);
      chk("stall_a3",    32'(A3_W), 32'd7);
      chk("stall_instr", Instr_W, 32'h0022_3821);
    end
    en = 1'b1; clr = 1'b1;
    drive({6'h03, 26'h0000C00}, 32'h0000_3000, 32'h0, 32'h0, 1'b0); cyc();
    chk("clr_instr", Instr_W, 32'h0);
    chk("clr_rw",    32'(RegWrite_W), 32'd0);
    clr = 1'b0;

    // lw $8 held, then reset during the stall
    drive(32'h8C08_0010, 32'h0000_0600, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0); cyc();
    chk("lw8_rw", 32'(RegWrite_W), 32'd1);
    en = 1'b0;
    drive(32'h0022_3821, 32'h0000_0700, 32'h1, 32'h2, 1'b0); cyc();
    chk("lw8_held_wd", WD_W, 32'hDEAD_BEEF);
    reset = 1'b1; cyc();
    chk("rst_stall_rw", 32'(RegWrite_W), 32'd0);
    chk("rst_stall_pc", PC_W, 32'h0);
    reset = 1'b0; en = 1'b1;

    // PC+8 wraps
    drive({6'h03, 26'h0000C00}, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0); cyc();
    chk("jal_wrap_wd", WD_W, 32'h0000_0004);

    // undefined opcode / func, write to $0, lui
    drive(32'hFC0C_0000, 32'h0000_0800, 32'h0000_ABCD, 32'h0, 1'b1); cyc();
    chk("undef_op_rw", 32'(RegWrite_W), 32'd0);
    chk("undef_op_a3", 32'(A3_W), 32'd12);
    chk("undef_op_wd", WD_W, 32'h0000_ABCD);
    drive(32'h002D_7018, 32'h0000_0804, 32'h0000_1111, 32'h0, 1'b1); cyc();
    chk("undef_fn_rw", 32'(RegWrite_W), 32'd0);
    chk("undef_fn_a3", 32'(A3_W), 32'd13);
    drive(32'h2420_0005, 32'h0000_0808, 32'h0000_0006, 32'h0, 1'b0); cyc();
    chk("addiu_r0_rw", 32'(RegWrite_W), 32'd0);
    drive(32'h3C14_1234, 32'h0000_080C, 32'h1234_0000, 32'h0, 1'b0); cyc();
    chk("lui_rw", 32'(RegWrite_W), 32'd1);
    chk("lui_a3", 32'(A3_W), 32'd20);
    cyc();

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mw_wb_stage.md
MW_WB_STAGE -- requirements
Module: mw_wb_stage

Interface
REQ-001 SHALL clock and reset as: one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high clear of all pipeline state.
REQ-004 SHALL have port en, input, 1 bit: 1 = capture the M-stage values, 0 = hold (stall).
REQ-005 SHALL have port clr, input, 1 bit: 1 = insert a bubble (flush) at the next edge.
REQ-006 SHALL have port Instr_M, input, 32 bits: the M-stage instruction word.
REQ-007 SHALL have port PC_M, input, 32 bits: the M-stage instruction address.
REQ-008 SHALL have port ALUOut_M, input, 32 bits: the ALU result, which is also the memory byte address.
REQ-009 SHALL have port DMRead_M, input, 32 bits: the raw aligned data-memory word.
REQ-010 SHALL have port CondOK_M, input, 1 bit: the movz condition (rt value == 0).
REQ-011 SHALL have port RegWrite_W, output, 1 bit: register-file write enable.
REQ-012 SHALL have port A3_W, output, 5 bits: write register number.
REQ-013 SHALL have port WD_W, output, 32 bits: write data.
REQ-014 SHALL have ports Instr_W and PC_W, output, 32 bits each: the W-stage copies, used by hazard logic and debug.

Function
REQ-015 SHALL register Instr, PC, ALUOut, DMRead and CondOK from M to W with 1-cycle latency; all W outputs derive only from these registers.
REQ-016 SHALL apply update priority reset > clr > en; when en=0 and clr=0, every register holds.
REQ-017 SHALL, on a bubble (reset or clr), load all registers with 0; Instr_W=0 decodes as sll $0 and produces RegWrite_W=0.
REQ-018 SHALL decode Mem2Reg and RegDst from Instr_W op[31:26] and func[5:0] with these encodings: Mem2Reg 00=ALU, 01=memory, 10=PC+8; RegDst 00=rt, 01=rd, 10=$31.
REQ-019 SHALL select A3_W as follows: rt = Instr_W[20:16], rd = Instr_W[15:11], or 5'd31.
REQ-020 SHALL select WD_W from ALUOut_W, the load-extended data, or PC_W+8 (32-bit, wraps modulo 2^32).
REQ-021 SHALL assert RegWrite_W only for the write set, and only when A3_W != 0. Write set: R-type ALU/shift/slt, jalr, movz with CondOK_W=1, ori/addi/addiu/andi/xori/slti/sltiu/lui, lw/lb/lbu/lh/lhu, jal.
REQ-022 SHALL extend load data using a=ALUOut_W[1:0] and little-endian byte k = DMRead_W[8k+7:8k]:
  - lw: the full word.
  - lb: sign-extended byte a.
  - lbu: zero-extended byte a.
  - lh: sign-extended half a[1].
  - lhu: zero-extended half a[1].
REQ-023 SHALL ignore misaligned address bits (lw ignores a; lh/lhu ignore a[0]); no exception is raised.
REQ-024 SHALL produce RegWrite_W=0, A3_W from RegDst=00, and WD_W=ALUOut_W for undefined opcodes and funcs.
REQ-025 SHALL hold WD_W, A3_W and RegWrite_W stable during a stall, so a held instruction writes on every held cycle (idempotent).

Reset
REQ-026 SHALL, at the first edge with reset=1, drive Instr_W=0, PC_W=0, RegWrite_W=0, A3_W=0 and WD_W=0; this holds regardless of en and clr.
REQ-027 SHALL, on reset mid-stall, discard the held instruction with no write issued after that edge.

Structure
REQ-028 SHALL place opcode and func constants and the Mem2Reg/RegDst encodings in a shared package used by all decoders.
REQ-029 SHALL implement the byte/half selector and extender as the combinational sub-module load_ext (inputs: word, a, op; output: 32 bits).
REQ-030 SHALL keep the M/W registers and the write-back mux in mw_wb_stage itself; it contains no other state.

Verification
REQ-031 SHALL cover: lb with DMRead_M=32'h80FF_1234 and ALUOut_M=...02 -> WD_W=32'hFFFF_FFFF one cycle later; lbu -> 32'h0000_00FF; lh with a=2 -> 32'hFFFF_80FF.
REQ-032 SHALL cover: jal at PC_M=32'h0000_3000 -> A3_W=31, WD_W=32'h0000_3008, RegWrite_W=1; jalr with rd=0 -> RegWrite_W=0.
REQ-033 SHALL cover: movz rd=5 with CondOK_M=0 -> RegWrite_W=0; with CondOK_M=1 -> RegWrite_W=1, A3_W=5.
REQ-034 SHALL cover: addu captured, then en=0 for 3 cycles while M inputs change -> W outputs unchanged; clr=1 with en=1 -> Instr_W=0, RegWrite_W=0.
REQ-035 SHALL cover: reset=1 during a stall holding lw $8 -> next cycle RegWrite_W=0, PC_W=0; PC_M=32'hFFFF_FFFC with jal -> WD_W=32'h0000_0004.
